// File: rtl/up_datapath_gen_if.sv
// up_datapath_gen_if
//  Bundle of every strobe and bus signal between up_control, the memory
//  interface and the up_datapath_gen datapath.
//  Parameters DW/AW/NREG must match the datapath instance.
//  Modports:
//    master - control/memory side: drives strobes, selects and data_in,
//             and observes data_out, addr_out, ir, flags and stack status.
//    slave  - datapath side: the mirror image of master.
interface up_datapath_gen_if #(
  parameter int DW   = 8,
  parameter int AW   = 8,
  parameter int NREG = 4
);
  localparam int RSW = $clog2(NREG);

  logic [DW-1:0]   data_in;
  logic            sel_a;
  logic            sel_b;
  logic [2:0]      alu_op;
  logic            flag_we;
  logic [RSW-1:0]  rs_a;
  logic [RSW-1:0]  rs_b;
  logic [RSW-1:0]  rd_a;
  logic [RSW-1:0]  rd_b;
  logic            we_a;
  logic            we_b;
  logic            pc_inc;
  logic            pc_load;
  logic            sp_push;
  logic            sp_pop;
  logic            addr_sel;
  logic            ir_we;
  logic            stat_clr;
  logic [DW-1:0]   data_out;
  logic [AW-1:0]   addr_out;
  logic [DW/2-1:0] ir;
  logic            flag_z;
  logic            flag_c;
  logic            stk_ovf;
  logic            stk_unf;

  modport master (
    output data_in, sel_a, sel_b, alu_op, flag_we, rs_a, rs_b, rd_a, rd_b,
           we_a, we_b, pc_inc, pc_load, sp_push, sp_pop, addr_sel, ir_we,
           stat_clr,
    input  data_out, addr_out, ir, flag_z, flag_c, stk_ovf, stk_unf
  );

  modport slave (
    input  data_in, sel_a, sel_b, alu_op, flag_we, rs_a, rs_b, rd_a, rd_b,
           we_a, we_b, pc_inc, pc_load, sp_push, sp_pop, addr_sel, ir_we,
           stat_clr,
    output data_out, addr_out, ir, flag_z, flag_c, stk_ovf, stk_unf
  );
endinterface

// File: rtl/up_datapath_gen.sv
// up_datapath_gen
//  Microprocessor datapath: NREG-entry dual-write register file, ALU with
//  registered Z/C flags, program counter (increment/load), stack pointer
//  (push/pop with optional guard) and a nibble-assembling instruction register.
//  All state changes take effect on the rising clk edge.
//  Ports:
//    clk    - rising-edge clock
//    nRst   - asynchronous active-low reset
//    dp_io  - up_datapath_gen_if.slave: control strobes, selects, data_in in;
//             data_out (ALU result), addr_out (PC/SP mux), ir, flags and
//             sticky stack status out.
//  Configuration macro:
//    UP_DP_STACK_GUARD_EN - when defined, push at SP==0 and pop at SP=={AW{1}}
//             hold SP and set stk_ovf / stk_unf; when undefined SP wraps and the
//             status outputs are tied to 0.
module up_datapath_gen #(
  parameter int            DW      = 8,
  parameter int            AW      = 8,
  parameter int            NREG    = 4,
  parameter logic [AW-1:0] SP_INIT = {AW{1'b1}}
) (
  input logic              clk,
  input logic              nRst,
  up_datapath_gen_if.slave dp_io
);
  localparam int            RSW    = $clog2(NREG);
  localparam int            HALF   = DW / 2;
  localparam int            MINW   = (AW < DW) ? AW : DW;
  localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASS_A, OP_PASS_B, OP_SHL
  } aluOp_e;

  logic [DW-1:0]   regs_q [NREG];
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW-1:0]   sp_q, sp_d;
  logic [HALF-1:0] ir_q, ir_d;
  logic            flagZ_q, flagZ_d;
  logic            flagC_q, flagC_d;

  logic [DW-1:0]   opA, opB, pcDw, aluRes;
  logic [AW-1:0]   pcLoad;
  logic [DW:0]     wide;
  logic            aluC;
  aluOp_e          aluOp;

  assign aluOp = aluOp_e'(dp_io.alu_op);

  // PC is zero-extended or truncated to DW for operand B, and the ALU result
  // is zero-extended or truncated to AW for a PC load.
  always_comb begin
    pcDw             = '0;
    pcDw[MINW-1:0]   = pc_q[MINW-1:0];
    pcLoad           = '0;
    pcLoad[MINW-1:0] = aluRes[MINW-1:0];
  end

  assign opA = dp_io.sel_a ? dp_io.data_in : regs_q[dp_io.rs_a];
  assign opB = dp_io.sel_b ? pcDw : regs_q[dp_io.rs_b];

  // ALU: the carry out of ADD and the borrow of SUB both appear in wide[DW];
  // logic and pass operations leave carry at 0.
  always_comb begin
    wide   = '0;
    aluRes = '0;
    aluC   = 1'b0;
    case (aluOp)
      OP_ADD: begin
        wide   = {1'b0, opA} + {1'b0, opB};
        aluRes = wide[DW-1:0];
        aluC   = wide[DW];
      end
      OP_SUB: begin
        wide   = {1'b0, opA} - {1'b0, opB};
        aluRes = wide[DW-1:0];
        aluC   = wide[DW];
      end
      OP_AND:    aluRes = opA & opB;
      OP_OR:     aluRes = opA | opB;
      OP_XOR:    aluRes = opA ^ opB;
      OP_PASS_A: aluRes = opA;
      OP_PASS_B: aluRes = opB;
      OP_SHL: begin
        aluRes = {opA[DW-2:0], 1'b0};
        aluC   = opA[DW-1];
      end
      default: aluRes = '0;
    endcase
  end

  // Next state for PC, flags and IR. The IR nibble choice uses the PC value
  // from before any same-cycle PC update.
  always_comb begin
    pc_d = pc_q;
    if (dp_io.pc_load) begin
      pc_d = pcLoad;
    end else if (dp_io.pc_inc) begin
      pc_d = pc_q + ONE_AW;
    end
    flagZ_d = flagZ_q;
    flagC_d = flagC_q;
    if (dp_io.flag_we) begin
      flagZ_d = (aluRes == '0);
      flagC_d = aluC;
    end
    ir_d = ir_q;
    if (dp_io.ir_we) begin
      ir_d = pc_q[0] ? dp_io.data_in[DW-1:HALF] : dp_io.data_in[HALF-1:0];
    end
  end

`ifdef UP_DP_STACK_GUARD_EN
  logic stkOvf_q, stkOvf_d;
  logic stkUnf_q, stkUnf_d;
  logic ovfEvt, unfEvt;

  // A push at the bottom or a pop at the top is refused and recorded; a new
  // event outranks a same-cycle stat_clr so it is never lost.
  always_comb begin
    ovfEvt = dp_io.sp_push && !dp_io.sp_pop && (sp_q == '0);
    unfEvt = dp_io.sp_pop && !dp_io.sp_push && (sp_q == '1);
    sp_d   = sp_q;
    if (dp_io.sp_push && !dp_io.sp_pop && !ovfEvt) begin
      sp_d = sp_q - ONE_AW;
    end else if (dp_io.sp_pop && !dp_io.sp_push && !unfEvt) begin
      sp_d = sp_q + ONE_AW;
    end
    stkOvf_d = ovfEvt ? 1'b1 : (dp_io.stat_clr ? 1'b0 : stkOvf_q);
    stkUnf_d = unfEvt ? 1'b1 : (dp_io.stat_clr ? 1'b0 : stkUnf_q);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stkOvf_q <= 1'b0;
      stkUnf_q <= 1'b0;
    end else begin
      stkOvf_q <= stkOvf_d;
      stkUnf_q <= stkUnf_d;
    end
  end

  assign dp_io.stk_ovf = stkOvf_q;
  assign dp_io.stk_unf = stkUnf_q;
`else
  logic unusedStatClr;

  always_comb begin
    sp_d = sp_q;
    if (dp_io.sp_push && !dp_io.sp_pop) begin
      sp_d = sp_q - ONE_AW;
    end else if (dp_io.sp_pop && !dp_io.sp_push) begin
      sp_d = sp_q + ONE_AW;
    end
  end

  assign unusedStatClr = dp_io.stat_clr;
  assign dp_io.stk_ovf = 1'b0;
  assign dp_io.stk_unf = 1'b0;
`endif

  // State registers. In the register file, port B is written first so that a
  // port A write to the same register overrides it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pc_q    <= '0;
      sp_q    <= SP_INIT;
      ir_q    <= '0;
      flagZ_q <= 1'b0;
      flagC_q <= 1'b0;
    end else begin
      if (dp_io.we_b) begin
        regs_q[dp_io.rd_b] <= dp_io.data_in;
      end
      if (dp_io.we_a) begin
        regs_q[dp_io.rd_a] <= aluRes;
      end
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ir_q    <= ir_d;
      flagZ_q <= flagZ_d;
      flagC_q <= flagC_d;
    end
  end

  assign dp_io.data_out = aluRes;
  assign dp_io.addr_out = dp_io.addr_sel ? sp_q : pc_q;
  assign dp_io.ir       = ir_q;
  assign dp_io.flag_z   = flagZ_q;
  assign dp_io.flag_c   = flagC_q;

  logic [RSW-1:0] unusedRsw;
  assign unusedRsw = '0;
endmodule

// File: tb/tb_up_datapath_gen.sv
// tb_up_datapath_gen
//  Directed testbench for up_datapath_gen (DW=8, AW=8, NREG=4). Each task
//  drives one scenario and compares DUT outputs against hand-computed values.
//  Stack checks follow UP_DP_STACK_GUARD_EN as compiled.
module tb_up_datapath_gen;
  logic clk;
  logic nRst;
  int   nChecks;
  int   nFails;

  up_datapath_gen_if #(.DW(8), .AW(8), .NREG(4)) bus ();

  up_datapath_gen #(.DW(8), .AW(8), .NREG(4)) dut (
    .clk   (clk),
    .nRst  (nRst),
    .dp_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Return every strobe and select to its inactive value.
  task automatic setIdle();
    bus.data_in  = 8'h00;
    bus.sel_a    = 1'b0;
    bus.sel_b    = 1'b0;
    bus.alu_op   = 3'd0;
    bus.flag_we  = 1'b0;
    bus.rs_a     = 2'd0;
    bus.rs_b     = 2'd0;
    bus.rd_a     = 2'd0;
    bus.rd_b     = 2'd0;
    bus.we_a     = 1'b0;
    bus.we_b     = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.sp_push  = 1'b0;
    bus.sp_pop   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_we    = 1'b0;
    bus.stat_clr = 1'b0;
  endtask

  // Advance one clock; inputs and outputs are touched 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeRegB(input logic [1:0] idx, input logic [7:0] val);
    setIdle();
    bus.we_b    = 1'b1;
    bus.rd_b    = idx;
    bus.data_in = val;
    tick();
    setIdle();
  endtask

  task automatic loadPc(input logic [7:0] val);
    setIdle();
    bus.sel_a   = 1'b1;
    bus.data_in = val;
    bus.alu_op  = 3'd5;
    bus.pc_load = 1'b1;
    tick();
    setIdle();
  endtask

  task automatic test_reset();
    loadPc(8'h33);
    bus.ir_we   = 1'b1;
    bus.data_in = 8'hAB;
    tick();
    setIdle();
    nChecks++; if (bus.ir !== 4'hA) begin nFails++; $display("[TB] FAIL pre_reset_ir: got %h expected %h", bus.ir, 4'hA); end
    bus.sel_a   = 1'b1;
    bus.data_in = 8'h80;
    bus.alu_op  = 3'd7;
    bus.flag_we = 1'b1;
    tick();
    setIdle();
    bus.we_b    = 1'b1;
    bus.rd_b    = 2'd3;
    bus.data_in = 8'h77;
    bus.pc_inc  = 1'b1;
    bus.sp_push = 1'b1;
    #2;
    nRst = 1'b0;
    #1;
    nChecks++; if (bus.addr_out !== 8'h00) begin nFails++; $display("[TB] FAIL reset_pc: got %h expected %h", bus.addr_out, 8'h00); end
    nChecks++; if (bus.ir !== 4'h0) begin nFails++; $display("[TB] FAIL reset_ir: got %h expected %h", bus.ir, 4'h0); end
    nChecks++; if (bus.flag_z !== 1'b0 || bus.flag_c !== 1'b0) begin nFails++; $display("[TB] FAIL reset_flags: got z=%b c=%b expected 0 0", bus.flag_z, bus.flag_c); end
    bus.addr_sel = 1'b1;
    #1;
    nChecks++; if (bus.addr_out !== 8'hFF) begin nFails++; $display("[TB] FAIL reset_sp: got %h expected %h", bus.addr_out, 8'hFF); end
    setIdle();
    tick();
    nRst = 1'b1;
    bus.rs_a   = 2'd3;
    bus.alu_op = 3'd5;
    #1;
    nChecks++; if (bus.data_out !== 8'h00) begin nFails++; $display("[TB] FAIL reset_no_write: got %h expected %h", bus.data_out, 8'h00); end
    setIdle();
  endtask

  task automatic test_alu();
    writeRegB(2'd0, 8'hF0);
    writeRegB(2'd1, 8'h20);
    bus.rs_a = 2'd0; bus.rs_b = 2'd1; bus.alu_op = 3'd0; bus.flag_we = 1'b1;
    #1;
    nChecks++; if (bus.data_out !== 8'h10) begin nFails++; $display("[TB] FAIL alu_add: got %h expected %h", bus.data_out, 8'h10); end
    tick();
    nChecks++; if (bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0) begin nFails++; $display("[TB] FAIL add_flags: got c=%b z=%b expected 1 0", bus.flag_c, bus.flag_z); end
    bus.rs_a = 2'd1; bus.rs_b = 2'd1; bus.alu_op = 3'd1;
    #1;
    nChecks++; if (bus.data_out !== 8'h00) begin nFails++; $display("[TB] FAIL alu_sub_eq: got %h expected %h", bus.data_out, 8'h00); end
    tick();
    nChecks++; if (bus.flag_z !== 1'b1 || bus.flag_c !== 1'b0) begin nFails++; $display("[TB] FAIL sub_eq_flags: got z=%b c=%b expected 1 0", bus.flag_z, bus.flag_c); end
    bus.rs_a = 2'd1; bus.rs_b = 2'd0;
    #1;
    nChecks++; if (bus.data_out !== 8'h30) begin nFails++; $display("[TB] FAIL alu_sub_borrow: got %h expected %h", bus.data_out, 8'h30); end
    tick();
    nChecks++; if (bus.flag_c !== 1'b1 || bus.flag_z !== 1'b0) begin nFails++; $display("[TB] FAIL borrow_flags: got c=%b z=%b expected 1 0", bus.flag_c, bus.flag_z); end
    bus.flag_we = 1'b0; bus.rs_a = 2'd0; bus.rs_b = 2'd1; bus.alu_op = 3'd2;
    #1;
    nChecks++; if (bus.data_out !== 8'h20) begin nFails++; $display("[TB] FAIL alu_and: got %h expected %h", bus.data_out, 8'h20); end
    tick();
    nChecks++; if (bus.flag_c !== 1'b1) begin nFails++; $display("[TB] FAIL flags_hold: got c=%b expected 1", bus.flag_c); end
    bus.alu_op = 3'd3;
    #1;
    nChecks++; if (bus.data_out !== 8'hF0) begin nFails++; $display("[TB] FAIL alu_or: got %h expected %h", bus.data_out, 8'hF0); end
    bus.alu_op = 3'd4;
    #1;
    nChecks++; if (bus.data_out !== 8'hD0) begin nFails++; $display("[TB] FAIL alu_xor: got %h expected %h", bus.data_out, 8'hD0); end
    bus.alu_op = 3'd7; bus.flag_we = 1'b1;
    #1;
    nChecks++; if (bus.data_out !== 8'hE0) begin nFails++; $display("[TB] FAIL alu_shl: got %h expected %h", bus.data_out, 8'hE0); end
    tick();
    nChecks++; if (bus.flag_c !== 1'b1) begin nFails++; $display("[TB] FAIL shl_carry: got c=%b expected 1", bus.flag_c); end
    bus.alu_op = 3'd5;
    tick();
    nChecks++; if (bus.flag_c !== 1'b0 || bus.flag_z !== 1'b0) begin nFails++; $display("[TB] FAIL pass_clears_c: got c=%b z=%b expected 0 0", bus.flag_c, bus.flag_z); end
    setIdle();
  endtask

  task automatic test_regfile();
    writeRegB(2'd3, 8'h55);
    bus.rs_a = 2'd3; bus.alu_op = 3'd5;
    bus.we_a = 1'b1; bus.rd_a = 2'd2;
    bus.we_b = 1'b1; bus.rd_b = 2'd2; bus.data_in = 8'hAA;
    tick();
    setIdle();
    bus.rs_a = 2'd2; bus.alu_op = 3'd5;
    #1;
    nChecks++; if (bus.data_out !== 8'h55) begin nFails++; $display("[TB] FAIL port_a_wins: got %h expected %h", bus.data_out, 8'h55); end
    bus.rs_a = 2'd1; bus.we_b = 1'b1; bus.rd_b = 2'd1; bus.data_in = 8'h99;
    #1;
    nChecks++; if (bus.data_out !== 8'h20) begin nFails++; $display("[TB] FAIL no_forwarding: got %h expected %h", bus.data_out, 8'h20); end
    tick();
    bus.we_b = 1'b0;
    #1;
    nChecks++; if (bus.data_out !== 8'h99) begin nFails++; $display("[TB] FAIL write_b: got %h expected %h", bus.data_out, 8'h99); end
    setIdle();
    bus.rs_a = 2'd3; bus.alu_op = 3'd5;
    bus.we_a = 1'b1; bus.rd_a = 2'd0;
    bus.we_b = 1'b1; bus.rd_b = 2'd1; bus.data_in = 8'hAA;
    tick();
    setIdle();
    bus.alu_op = 3'd5; bus.rs_a = 2'd0;
    #1;
    nChecks++; if (bus.data_out !== 8'h55) begin nFails++; $display("[TB] FAIL dual_write_a: got %h expected %h", bus.data_out, 8'h55); end
    bus.rs_a = 2'd1;
    #1;
    nChecks++; if (bus.data_out !== 8'hAA) begin nFails++; $display("[TB] FAIL dual_write_b: got %h expected %h", bus.data_out, 8'hAA); end
    setIdle();
  endtask

  task automatic test_pc_ir();
    loadPc(8'hFF);
    #1;
    nChecks++; if (bus.addr_out !== 8'hFF) begin nFails++; $display("[TB] FAIL pc_load: got %h expected %h", bus.addr_out, 8'hFF); end
    bus.pc_inc = 1'b1;
    tick();
    nChecks++; if (bus.addr_out !== 8'h00) begin nFails++; $display("[TB] FAIL pc_wrap: got %h expected %h", bus.addr_out, 8'h00); end
    setIdle();
    bus.sel_a = 1'b1; bus.data_in = 8'h40; bus.alu_op = 3'd5;
    bus.pc_load = 1'b1; bus.pc_inc = 1'b1;
    tick();
    nChecks++; if (bus.addr_out !== 8'h40) begin nFails++; $display("[TB] FAIL load_priority: got %h expected %h", bus.addr_out, 8'h40); end
    setIdle();
    bus.sel_b = 1'b1; bus.alu_op = 3'd6;
    #1;
    nChecks++; if (bus.data_out !== 8'h40) begin nFails++; $display("[TB] FAIL pass_b_pc: got %h expected %h", bus.data_out, 8'h40); end
    loadPc(8'h01);
    bus.ir_we = 1'b1; bus.data_in = 8'hC3;
    tick();
    nChecks++; if (bus.ir !== 4'hC) begin nFails++; $display("[TB] FAIL ir_high: got %h expected %h", bus.ir, 4'hC); end
    bus.data_in = 8'h5A; bus.pc_inc = 1'b1;
    tick();
    nChecks++; if (bus.ir !== 4'h5 || bus.addr_out !== 8'h02) begin nFails++; $display("[TB] FAIL ir_old_pc: got ir=%h pc=%h expected 5 02", bus.ir, bus.addr_out); end
    bus.pc_inc = 1'b0;
    tick();
    nChecks++; if (bus.ir !== 4'hA) begin nFails++; $display("[TB] FAIL ir_low: got %h expected %h", bus.ir, 4'hA); end
    setIdle();
  endtask

  task automatic test_stack();
    setIdle();
    bus.addr_sel = 1'b1;
`ifdef UP_DP_STACK_GUARD_EN
    bus.sp_push = 1'b1;
    repeat (255) tick();
    nChecks++; if (bus.addr_out !== 8'h00) begin nFails++; $display("[TB] FAIL sp_descend: got %h expected %h", bus.addr_out, 8'h00); end
    tick();
    nChecks++; if (bus.addr_out !== 8'h00 || bus.stk_ovf !== 1'b1) begin nFails++; $display("[TB] FAIL guard_ovf: got sp=%h ovf=%b expected 00 1", bus.addr_out, bus.stk_ovf); end
    bus.stat_clr = 1'b1;
    tick();
    nChecks++; if (bus.stk_ovf !== 1'b1) begin nFails++; $display("[TB] FAIL event_beats_clr: got ovf=%b expected 1", bus.stk_ovf); end
    bus.sp_push = 1'b0;
    tick();
    nChecks++; if (bus.stk_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL stat_clr_ovf: got ovf=%b expected 0", bus.stk_ovf); end
    bus.stat_clr = 1'b0; bus.sp_pop = 1'b1;
    repeat (255) tick();
    nChecks++; if (bus.addr_out !== 8'hFF) begin nFails++; $display("[TB] FAIL sp_ascend: got %h expected %h", bus.addr_out, 8'hFF); end
    tick();
    nChecks++; if (bus.addr_out !== 8'hFF || bus.stk_unf !== 1'b1) begin nFails++; $display("[TB] FAIL guard_unf: got sp=%h unf=%b expected FF 1", bus.addr_out, bus.stk_unf); end
    bus.sp_push = 1'b1;
    tick();
    nChecks++; if (bus.addr_out !== 8'hFF || bus.stk_unf !== 1'b1) begin nFails++; $display("[TB] FAIL push_pop_hold: got sp=%h unf=%b expected FF 1", bus.addr_out, bus.stk_unf); end
    bus.sp_push = 1'b0; bus.sp_pop = 1'b0; bus.stat_clr = 1'b1;
    tick();
    nChecks++; if (bus.stk_unf !== 1'b0) begin nFails++; $display("[TB] FAIL stat_clr_unf: got unf=%b expected 0", bus.stk_unf); end
`else
    bus.sp_pop = 1'b1;
    tick();
    nChecks++; if (bus.addr_out !== 8'h00 || bus.stk_unf !== 1'b0) begin nFails++; $display("[TB] FAIL pop_wrap: got sp=%h unf=%b expected 00 0", bus.addr_out, bus.stk_unf); end
    bus.sp_pop = 1'b0; bus.sp_push = 1'b1;
    tick();
    nChecks++; if (bus.addr_out !== 8'hFF) begin nFails++; $display("[TB] FAIL push_dec: got %h expected %h", bus.addr_out, 8'hFF); end
    repeat (255) tick();
    nChecks++; if (bus.addr_out !== 8'h00) begin nFails++; $display("[TB] FAIL sp_descend: got %h expected %h", bus.addr_out, 8'h00); end
    tick();
    nChecks++; if (bus.addr_out !== 8'hFF || bus.stk_ovf !== 1'b0) begin nFails++; $display("[TB] FAIL push_wrap: got sp=%h ovf=%b expected FF 0", bus.addr_out, bus.stk_ovf); end
    bus.sp_pop = 1'b1;
    tick();
    nChecks++; if (bus.addr_out !== 8'hFF) begin nFails++; $display("[TB] FAIL push_pop_hold: got %h expected %h", bus.addr_out, 8'hFF); end
`endif
    setIdle();
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    nRst    = 1'b0;
    setIdle();
    repeat (2) tick();
    nRst = 1'b1;
    tick();
    test_reset();
    test_alu();
    test_regfile();
    test_pc_ir();
    test_stack();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
